// File: rtl/fsm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fsm_seq_ctrl
//
// Bring-up controller for a single-bit serial FSM. On an accepted start it
// latches a pattern of len bits and shifts it onto x_out MSB-first (bit len-1
// first), one bit per clock, then drives FLUSH_CYC idle-zero cycles. Every
// clock edge spent shifting or flushing counts a y_in pulse into a saturating
// hit counter. A one-cycle DONE state closes each normal run.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   run request, sampled only while idle
//   abort    in   synchronous cancel of an active run
//   pattern  in   [PAT_W-1:0] bits to send, bit len-1 first
//   len      in   [LEN_W-1:0] pattern length, legal range 1..PAT_W
//   y_in     in   output y of the FSM under test
//   x_out    out  input x of the FSM under test (registered)
//   busy     out  run in progress (shifting or flushing)
//   done     out  one-cycle pulse, run completed normally
//   err      out  one-cycle pulse, start refused because of illegal len
//   aborted  out  one-cycle pulse, run cancelled by abort
//   hit_cnt  out  [CNT_W-1:0] y pulses counted in the last/current run
// -----------------------------------------------------------------------------
module fsm_seq_ctrl #(
    parameter int PAT_W     = 16,
    parameter int LEN_W     = 5,
    parameter int CNT_W     = 5,
    parameter int FLUSH_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             y_in,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             aborted,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [FC_W-1:0]  FC_LOAD  = FC_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q,   state_d;
    logic [PAT_W-1:0] pat_q,     pat_d;
    logic [IDX_W-1:0] idx_q,     idx_d;     // index of the bit now on x_out
    logic [FC_W-1:0]  fcnt_q,    fcnt_d;    // flush cycles still to go, minus one
    logic             x_q,       x_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;
    logic             aborted_q, aborted_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic             len_ok;
    logic [IDX_W-1:0] len_idx;
    logic [IDX_W-1:0] idx_nxt;

    assign len_ok  = (len != '0) && (len <= LEN_MAX);
    assign len_idx = IDX_W'(len - LEN_W'(1));
    assign idx_nxt = idx_q - IDX_W'(1);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d signal is given a default before the case so that no
        // path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        pat_d     = pat_q;
        idx_d     = idx_q;
        fcnt_d    = fcnt_q;
        x_d       = 1'b0;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        aborted_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // abort is deliberately not looked at here: start wins.
                if (start) begin
                    if (len_ok) begin
                        pat_d   = pattern;
                        idx_d   = len_idx;
                        x_d     = pattern[len_idx];
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_SHIFT, S_FLUSH: begin
                if (abort) begin
                    // The cancelling edge itself does not count y_in.
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    if (y_in && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (state_q == S_SHIFT) begin
                        if (idx_q == '0) begin
                            fcnt_d  = FC_LOAD;
                            state_d = S_FLUSH;
                        end else begin
                            idx_d = idx_nxt;
                            x_d   = pat_q[idx_nxt];
                        end
                    end else begin
                        if (fcnt_q == '0) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            fcnt_d = fcnt_q - FC_W'(1);
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            idx_q     <= '0;
            fcnt_q    <= '0;
            x_q       <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // only, so every register sees the pre-edge values of the others.
            state_q   <= state_d;
            pat_q     <= pat_d;
            idx_q     <= idx_d;
            fcnt_q    <= fcnt_d;
            x_q       <= x_d;
            done_q    <= done_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
            cnt_q     <= cnt_d;
        end
    end

    assign x_out   = x_q;
    assign busy    = (state_q == S_SHIFT) || (state_q == S_FLUSH);
    assign done    = done_q;
    assign err     = err_q;
    assign aborted = aborted_q;
    assign hit_cnt = cnt_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fsm_seq_ctrl
//
// Self-checking bench for fsm_seq_ctrl. A table of single-edge idle vectors
// covers start/abort/len decoding; hand-written runs cover the multi-cycle
// corner cases; randomized runs are checked against a per-cycle model that
// derives x_out/busy/done/aborted/hit_cnt directly from the run's offset
// relative to the accepting edge.
// -----------------------------------------------------------------------------
module tb_fsm_seq_ctrl;

    localparam int PAT_W     = 16;
    localparam int LEN_W     = 5;
    localparam int CNT_W     = 4;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             y_in;
    logic             x_out;
    logic             busy;
    logic             done;
    logic             err;
    logic             aborted;
    logic [CNT_W-1:0] hit_cnt;

    fsm_seq_ctrl #(
        .PAT_W     (PAT_W),
        .LEN_W     (LEN_W),
        .CNT_W     (CNT_W),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .pattern (pattern),
        .len     (len),
        .y_in    (y_in),
        .x_out   (x_out),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .aborted (aborted),
        .hit_cnt (hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle; outputs are read 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // y pulses on edges 1..upto of a run, saturated.
    function automatic int exp_hit(input logic [31:0] ymask, input int upto);
        int c;
        c = 0;
        for (int e = 1; e <= upto; e++) begin
            if (ymask[e]) c++;
        end
        return (c > CNT_MAX) ? CNT_MAX : c;
    endfunction

    // One full run from idle. ymask bit j is y_in at edge T+j; abort_at is the
    // edge offset of an abort (0 = none); restart_at is an offset at which a
    // second start is pulsed (0 = none) and must be ignored.
    task automatic do_run(input string tag, input logic [PAT_W-1:0] pat, input int l,
                          input logic [31:0] ymask, input int abort_at, input int restart_at);
        int  last;
        int  lend;
        int  run_end;
        logic ex, eb, ed, ea;
        run_end = l + FLUSH_CYC;
        last    = (abort_at > 0) ? abort_at - 1 : run_end;
        lend    = run_end + 1;
        for (int j = 0; j <= lend; j++) begin
            if (j == 0) begin
                start   = 1'b1;
                pattern = pat;
                len     = LEN_W'(l);
            end else begin
                start   = (j == restart_at);
                pattern = PAT_W'($urandom);
                len     = LEN_W'($urandom_range(1, PAT_W));
            end
            abort = (j > 0) && (j == abort_at);
            y_in  = ymask[j];
            step();
            if (abort_at > 0 && j >= abort_at) begin
                ex = 1'b0;
                eb = 1'b0;
                ed = 1'b0;
                ea = (j == abort_at);
            end else begin
                ex = (j < l) ? pat[l-1-j] : 1'b0;
                eb = (j < run_end);
                ed = (j == run_end);
                ea = 1'b0;
            end
            check($sformatf("%s j%0d x_out", tag, j),   x_out,   ex);
            check($sformatf("%s j%0d busy", tag, j),    busy,    eb);
            check($sformatf("%s j%0d done", tag, j),    done,    ed);
            check($sformatf("%s j%0d aborted", tag, j), aborted, ea);
            check($sformatf("%s j%0d err", tag, j),     err,     1'b0);
            check($sformatf("%s j%0d hit_cnt", tag, j), hit_cnt,
                  exp_hit(ymask, (j < last) ? j : last));
        end
        start = 1'b0;
        abort = 1'b0;
        y_in  = 1'b0;
    endtask

    typedef struct {
        logic             start;
        logic             abort;
        logic [LEN_W-1:0] len;
        logic [PAT_W-1:0] pat;
        logic             exp_err;
        logic             exp_busy;
        logic             exp_x;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int l;
        int ab;
        int rs;

        vecs[0] = '{1'b0, 1'b0, 5'd4,  16'h000B, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 5'd4,  16'h000B, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 5'd0,  16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 5'd17, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 5'd31, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 5'd0,  16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 5'd4,  16'h000B, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 5'd1,  16'h0001, 1'b0, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 5'd16, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 5'd16, 16'h8000, 1'b0, 1'b1, 1'b1};

        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        y_in    = 1'b0;

        // Reset state, both during and just after reset.
        step();
        step();
        check("rst x_out",   x_out,   1'b0);
        check("rst busy",    busy,    1'b0);
        check("rst done",    done,    1'b0);
        check("rst err",     err,     1'b0);
        check("rst aborted", aborted, 1'b0);
        check("rst hit_cnt", hit_cnt, 0);
        rst_n = 1'b1;
        step();
        check("post-rst busy",  busy,  1'b0);
        check("post-rst x_out", x_out, 1'b0);

        // Single-edge idle decoding table.
        for (int i = 0; i < 10; i++) begin
            start   = vecs[i].start;
            abort   = vecs[i].abort;
            len     = vecs[i].len;
            pattern = vecs[i].pat;
            step();
            start = 1'b0;
            abort = 1'b0;
            check($sformatf("vec%0d err", i),     err,     vecs[i].exp_err);
            check($sformatf("vec%0d busy", i),    busy,    vecs[i].exp_busy);
            check($sformatf("vec%0d x_out", i),   x_out,   vecs[i].exp_x);
            check($sformatf("vec%0d aborted", i), aborted, 1'b0);
            check($sformatf("vec%0d done", i),    done,    1'b0);
            check($sformatf("vec%0d hit_cnt", i), hit_cnt, 0);
            if (vecs[i].exp_busy) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                check($sformatf("vec%0d abort aborted", i), aborted, 1'b1);
                check($sformatf("vec%0d abort busy", i),    busy,    1'b0);
                check($sformatf("vec%0d abort x_out", i),   x_out,   1'b0);
            end
            step();
            check($sformatf("vec%0d settle err", i),     err,     1'b0);
            check($sformatf("vec%0d settle aborted", i), aborted, 1'b0);
        end

        // Basic run, counting run (edge 7 is the DONE cycle), saturation.
        do_run("basic", 16'h000B, 4, 32'h0, 0, 0);
        do_run("count", 16'h000B, 4, 32'h0000_00D4, 0, 0);
        do_run("sat", 16'hFFFF, 16, 32'hFFFF_FFFF, 0, 0);

        // Illegal len after a saturated run leaves hit_cnt untouched.
        start = 1'b1;
        len   = 5'd17;
        step();
        start = 1'b0;
        check("illegal err",     err,     1'b1);
        check("illegal busy",    busy,    1'b0);
        check("illegal x_out",   x_out,   1'b0);
        check("illegal hit_cnt", hit_cnt, CNT_MAX);
        step();
        check("illegal err clears", err, 1'b0);

        // Re-start while busy, and a start during the DONE cycle.
        do_run("restart", 16'h00A5, 8, 32'h0000_0122, 0, 3);
        do_run("done-start", 16'h0036, 6, 32'h0, 0, 9);

        // Abort at edge T+3: only edges T+1..T+2 are counted.
        do_run("abort", 16'h00C3, 8, 32'h0000_000E, 3, 0);
        do_run("abort-last", 16'h0005, 3, 32'h0000_003E, 5, 0);

        // Asynchronous reset in the middle of SHIFT.
        start   = 1'b1;
        pattern = 16'h00A5;
        len     = 5'd8;
        y_in    = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre-arst hit_cnt", hit_cnt, 2);
        check("pre-arst x_out",   x_out,   1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst x_out",   x_out,   1'b0);
        check("arst busy",    busy,    1'b0);
        check("arst hit_cnt", hit_cnt, 0);
        start = 1'b1;
        step();
        step();
        check("arst held busy",    busy,    1'b0);
        check("arst held done",    done,    1'b0);
        check("arst held aborted", aborted, 1'b0);
        check("arst held hit_cnt", hit_cnt, 0);
        start = 1'b0;
        y_in  = 1'b0;
        rst_n = 1'b1;
        step();
        do_run("after-arst", 16'h0B2D, 12, 32'h0000_5A5A, 0, 0);

        // Randomized back-to-back runs.
        for (int i = 0; i < 30; i++) begin
            l  = $urandom_range(1, PAT_W);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, l + FLUSH_CYC) : 0;
            if ($urandom_range(0, 1) == 1) begin
                rs = (ab > 0) ? $urandom_range(1, ab) : $urandom_range(1, l + FLUSH_CYC + 1);
            end else begin
                rs = 0;
            end
            do_run($sformatf("rnd%0d", i), PAT_W'($urandom), l, $urandom, ab, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fsm_seq_ctrl.md
Name: fsm_seq_ctrl

Overview:
Test/bring-up controller for the single-bit serial FSM (input x, output y). It loads a programmed bit pattern and shifts it serially onto the FSM input, one bit per clock. It then drives a fixed number of idle-zero flush cycles and counts the y pulses returned over the whole run. A start/busy/done handshake lets a host or testbench run detection sequences back-to-back without hand-toggling x.

Parameters:
PAT_W, 16, maximum pattern length in bits
LEN_W, 5, width of len input (must hold PAT_W)
CNT_W, 5, width of hit counter (saturating)
FLUSH_CYC, 2, zero-driven cycles after last pattern bit (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a run; sampled only in IDLE
abort  in  1  synchronous cancel of an active run
pattern  in  PAT_W  bits to send; bit len-1 sent first
len  in  LEN_W  number of pattern bits, valid 1..PAT_W
y_in  in  1  FSM output y
x_out  out  1  FSM input x (registered)
busy  out  1  run in progress
done  out  1  one-cycle pulse, run completed normally
err  out  1  one-cycle pulse, start with illegal len
aborted  out  1  one-cycle pulse, run cancelled
hit_cnt  out  CNT_W  y pulses counted in last/current run

Behaviour:
- Reset (rst_n low, async): state=IDLE; x_out=0, busy=0, done=0, err=0, aborted=0, hit_cnt=0; internal shift reg and bit index cleared. Reset mid-run discards the run; no done/aborted pulse.
- States: IDLE, SHIFT, FLUSH, DONE.
- IDLE: x_out=0, busy=0. At edge T, if start=1:
  - len in 1..PAT_W: latch pattern and len; clear hit_cnt; load x_out with pattern[len-1]; busy=1; go SHIFT.
  - len=0 or len>PAT_W: err=1 for the cycle after T; stay IDLE; hit_cnt unchanged.
- SHIFT: bit k (k=0..len-1) = pattern[len-1-k]; it is on x_out from edge T+k to edge T+k+1. At edge T+len, x_out<=0 and state goes to FLUSH.
- FLUSH: x_out=0 for FLUSH_CYC cycles. At edge T+len+FLUSH_CYC, go to DONE.
- DONE: lasts one cycle. done=1, busy=0, x_out=0. Next edge goes to IDLE. A start seen during the DONE cycle is ignored.
- Counting: at every edge where the current state is SHIFT or FLUSH, hit_cnt increments if y_in=1. That covers edges T+1..T+len+FLUSH_CYC. hit_cnt saturates at 2^CNT_W-1, with no wrap. It holds its value after done until the next accepted start.
- Run length: busy high from edge T to edge T+len+FLUSH_CYC, i.e. len+FLUSH_CYC cycles. The done pulse is in the following cycle.
- start while busy: ignored; no queuing.
- abort=1 at an edge while in SHIFT or FLUSH:
  - next state IDLE; x_out=0, busy=0; aborted=1 for one cycle; no done.
  - hit_cnt keeps its partial value, and y_in is not counted at that edge.
- abort in IDLE or DONE: no effect.
- abort and start at the same edge in IDLE: start wins; abort is ignored.
- Pattern bits above len-1 are don't-care.
- Changes on the pattern/len inputs during a run have no effect.
- Pulse outputs (done, err, aborted) are mutually exclusive and registered.

Test Plan:
- Basic run: reset; pattern=16'h000B, len=4, FLUSH_CYC=2; pulse start. Expect x_out sequence 1,0,1,1,0,0 on consecutive cycles, busy high for 6 cycles, done one cycle after, hit_cnt=0 with y_in held 0.
- Counting: same run with bench driving y_in=1 for exactly 3 sampled cycles (edges T+2, T+4, T+6). Expect hit_cnt=3 at done. A y_in pulse at edge T+7 (DONE) is not counted.
- Saturation: len=16, pattern=16'hFFFF, y_in tied 1 for the whole run (18 sampled edges), CNT_W=4. Expect hit_cnt=15 at done, no wrap.
- Illegal len and busy start: start with len=0 gives err pulse, busy stays 0, x_out=0. start with len=17 also gives err. During a valid len=8 run, re-pulsing start gives no effect and done arrives exactly at cycle T+10.
- Abort: len=8 run, abort at edge T+3. Expect x_out=0 and busy=0 after that edge, aborted pulse, no done, hit_cnt = count over edges T+1..T+2.
- Async reset: assert rst_n=0 mid-SHIFT between clock edges. Expect x_out, busy, hit_cnt go to 0 immediately without waiting for clk. After release, a new start runs normally.
